// File: rtl/phase2_control_sequencer_pkg.sv
// Shared definitions for the phase-2 hardwired control sequencer:
// state encoding, opcode constants and IR field geometry.
package phase2_control_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_HALT,
      ST_FAULT
   } state_t;

   localparam int IR_W   = 32;
   localparam int IR_MSB = IR_W - 1;

   localparam int DEF_REG_COUNT = 16;
   localparam int DEF_REG_SEL_W = 4;
   localparam int DEF_OP_W      = 5;
   localparam int DEF_WAIT_MAX  = 15;

   // Opcodes 0 .. DEF_ALU_OPS-1 are register-register ALU instructions.
   localparam int          DEF_ALU_OPS = 13;
   localparam logic [4:0]  DEF_HALT_OP = 5'b11011;

   function automatic logic sel_in_range(input int sel, input int count);
      return (sel >= 0) && (sel < count);
   endfunction

endpackage

// File: rtl/phase2_reg_decode.sv
// Register-field to one-hot decoder with enable; flags selectors that
// name a register the file does not have.
module phase2_reg_decode
   import phase2_control_sequencer_pkg::*;
#(
   parameter int REG_COUNT = DEF_REG_COUNT,
   parameter int REG_SEL_W = DEF_REG_SEL_W
) (
   input  logic                 en,
   input  logic [REG_SEL_W-1:0] sel,
   output logic [REG_COUNT-1:0] onehot,
   output logic                 out_of_range
);

   // NOTE: every output gets a default before any condition, so no latch is inferred.
   always_comb begin
      out_of_range = !sel_in_range(int'(sel), REG_COUNT);
      onehot       = '0;
      if (en && !out_of_range) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            onehot[i] = (int'(sel) == i);
         end
      end
   end

endmodule

// File: rtl/phase2_control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and register-register ALU execute
// (T3-T5) with run/stop, memory wait timeout, halt and illegal-opcode handling.
module phase2_control_sequencer
   import phase2_control_sequencer_pkg::*;
#(
   parameter int              REG_COUNT = DEF_REG_COUNT,
   parameter int              REG_SEL_W = DEF_REG_SEL_W,
   parameter int              OP_W      = DEF_OP_W,
   parameter int              ALU_OPS   = DEF_ALU_OPS,
   parameter logic [OP_W-1:0] HALT_OP   = OP_W'(DEF_HALT_OP),
   parameter int              WAIT_MAX  = DEF_WAIT_MAX
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Run,
   input  logic                 MemReady,
   input  logic [IR_W-1:0]      IR_data,
   output logic                 PCout,
   output logic                 ZLOout,
   output logic                 MDRout,
   output logic                 MARin,
   output logic                 Zin,
   output logic                 PCin,
   output logic                 MDRin,
   output logic                 IRin,
   output logic                 Yin,
   output logic                 IncrementPC,
   output logic                 Read,
   output logic [REG_COUNT-1:0] Rin,
   output logic [REG_COUNT-1:0] Rout,
   output logic [OP_W-1:0]      ALUControl,
   output logic                 Halted,
   output logic                 Fault,
   output logic                 Illegal,
   output logic [31:0]          InstrCount
);

   // Fields are packed contiguously from the IR MSB downward: op, Ra, Rb, Rc.
   localparam int OP_LSB = IR_MSB - OP_W + 1;
   localparam int RA_LSB = OP_LSB - REG_SEL_W;
   localparam int RB_LSB = RA_LSB - REG_SEL_W;
   localparam int RC_LSB = RB_LSB - REG_SEL_W;
   localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;

   logic [OP_W-1:0]      op;
   logic [REG_SEL_W-1:0] ra;
   logic [REG_SEL_W-1:0] rb;
   logic [REG_SEL_W-1:0] rc;
   logic                 is_halt;
   logic                 instr_ok;
   logic                 ra_bad;
   logic                 rsrc_bad;
   logic                 rout_en;
   logic [REG_SEL_W-1:0] rout_sel;
   logic                 unused_ir;

   assign op        = IR_data[OP_LSB +: OP_W];
   assign ra        = IR_data[RA_LSB +: REG_SEL_W];
   assign rb        = IR_data[RB_LSB +: REG_SEL_W];
   assign rc        = IR_data[RC_LSB +: REG_SEL_W];
   assign unused_ir = ^IR_data[RC_LSB-1:0];

   assign is_halt  = (op == HALT_OP);
   // In T3 the source decoder looks at Rb, so its range flag validates Rb.
   assign instr_ok = (int'(op) < ALU_OPS) && !ra_bad && !rsrc_bad
                     && sel_in_range(int'(rc), REG_COUNT);

   assign rout_sel = (state == ST_T4) ? rc : rb;
   assign rout_en  = ((state == ST_T3) && !is_halt && instr_ok) || (state == ST_T4);

   phase2_reg_decode #(
      .REG_COUNT (REG_COUNT),
      .REG_SEL_W (REG_SEL_W)
   ) u_rin_decode (
      .en           (state == ST_T5),
      .sel          (ra),
      .onehot       (Rin),
      .out_of_range (ra_bad)
   );

   phase2_reg_decode #(
      .REG_COUNT (REG_COUNT),
      .REG_SEL_W (REG_SEL_W)
   ) u_rout_decode (
      .en           (rout_en),
      .sel          (rout_sel),
      .onehot       (Rout),
      .out_of_range (rsrc_bad)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of its neighbours.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         InstrCount <= '0;
         Halted     <= 1'b0;
         Fault      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Run) state <= ST_T0;
            end
            ST_T0: begin
               wait_cnt <= '0;
               state    <= ST_T1;
            end
            ST_T1: begin
               if (MemReady) begin
                  state <= ST_T2;
               end else if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
                  state <= ST_FAULT;
                  Fault <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_T2: state <= ST_T3;
            ST_T3: begin
               if (is_halt) begin
                  state      <= ST_HALT;
                  Halted     <= 1'b1;
                  InstrCount <= InstrCount + 32'd1;
               end else if (instr_ok) begin
                  state <= ST_T4;
               end else begin
                  state <= Run ? ST_T0 : ST_IDLE;
               end
            end
            ST_T4: state <= ST_T5;
            ST_T5: begin
               InstrCount <= InstrCount + 32'd1;
               state      <= Run ? ST_T0 : ST_IDLE;
            end
            ST_HALT:  state <= ST_HALT;
            ST_FAULT: state <= ST_FAULT;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Strobes are decoded from the registered state; only T1 looks at MemReady.
   always_comb begin
      PCout       = 1'b0;
      ZLOout      = 1'b0;
      MDRout      = 1'b0;
      MARin       = 1'b0;
      Zin         = 1'b0;
      PCin        = 1'b0;
      MDRin       = 1'b0;
      IRin        = 1'b0;
      Yin         = 1'b0;
      IncrementPC = 1'b0;
      Read        = 1'b0;
      ALUControl  = '0;
      Illegal     = 1'b0;
      case (state)
         ST_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            Zin   = 1'b1;
         end
         ST_T1: begin
            Read  = 1'b1;
            MDRin = 1'b1;
            if (MemReady) begin
               ZLOout      = 1'b1;
               PCin        = 1'b1;
               IncrementPC = 1'b1;
            end
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            if (!is_halt) begin
               if (instr_ok) Yin     = 1'b1;
               else          Illegal = 1'b1;
            end
         end
         ST_T4: begin
            Zin        = 1'b1;
            ALUControl = op;
         end
         ST_T5: ZLOout = 1'b1;
         default: ;
      endcase
   end

endmodule
